// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response bundle between the control FSM and the
// sequenced ALU.
//   master (control side): drives Start, FS, Data_in_A, Data_in_B;
//                          observes Result_out, Flags_out, Busy, Done, Halted, Err.
//   slave  (ALU side):     the mirror image.
// Flags_out is packed as {Z, N, C, V}.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [3:0]       FS;
  logic [WIDTH-1:0] Data_in_A;
  logic [WIDTH-1:0] Data_in_B;
  logic [WIDTH-1:0] Result_out;
  logic [3:0]       Flags_out;
  logic             Busy;
  logic             Done;
  logic             Halted;
  logic             Err;

  modport master (
    output Start, FS, Data_in_A, Data_in_B,
    input  Result_out, Flags_out, Busy, Done, Halted, Err
  );

  modport slave (
    input  Start, FS, Data_in_A, Data_in_B,
    output Result_out, Flags_out, Busy, Done, Halted, Err
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered result and {Z,N,C,V} flags,
// single-cycle logic/arithmetic/shift operations, a WIDTH-cycle shift-add
// multiplier and a sticky halt state.
//   CLK      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      alu_seq_unit_if.slave: Start/FS/Data_in_A/Data_in_B in,
//            Result_out/Flags_out/Busy/Done/Halted/Err out
module alu_seq_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         CLK,
  input  logic         Reset_n,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   a, b, alu_r;
  logic               alu_c, alu_v, a_min;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_x, sub_x, shl_x, shr_x;
  logic [2*WIDTH-1:0] mul_sum;

  // Single-cycle datapath, evaluated directly on the presented operands.
  always_comb begin
    a     = bus.Data_in_A;
    b     = bus.Data_in_B;
    shamt = b[SW-1:0];
    add_x = {1'b0, a} + {1'b0, b};
    sub_x = {1'b0, b} - {1'b0, a};
    // The extra bit above (SHL) or below (SHR) catches the last bit shifted
    // out; a zero shift leaves it 0.
    shl_x = {1'b0, a} << shamt;
    shr_x = {a, 1'b0} >> shamt;
    a_min = (a == {1'b1, {(WIDTH-1){1'b0}}});
    alu_r = a;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.FS)
      4'd1: begin
        alu_r = add_x[WIDTH-1:0];
        alu_c = add_x[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: begin
        alu_r = sub_x[WIDTH-1:0];
        alu_c = sub_x[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != b[WIDTH-1]);
      end
      4'd3: begin
        alu_r = a[WIDTH-1] ? -a : a;
        alu_v = a_min;
      end
      4'd4:  alu_r = ~a;
      4'd5:  alu_r = a & b;
      4'd6: begin
        alu_r = -a;
        alu_v = a_min;
      end
      4'd8:  alu_r = a | b;
      4'd9:  alu_r = a ^ b;
      4'd10: begin
        alu_r = shl_x[WIDTH-1:0];
        alu_c = shl_x[WIDTH];
      end
      4'd11: begin
        alu_r = shr_x[WIDTH:1];
        alu_c = shr_x[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mul_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          case (bus.FS)
            4'd7:  state_d = S_HALT;
            4'd12: begin
              state_d  = S_MUL_RUN;
              prod_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              cnt_d    = '0;
            end
            4'd13, 4'd14, 4'd15: err_d = 1'b1;
            default: begin
              result_d = alu_r;
              flags_d  = {alu_r == '0, alu_r[WIDTH-1], alu_c, alu_v};
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL_RUN: begin
        // Partial product lives in prod_q only; Result_out is written once,
        // on the final iteration, straight from the last sum.
        prod_d   = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_IDLE;
          result_d = mul_sum[WIDTH-1:0];
          flags_d  = {mul_sum[WIDTH-1:0] == '0, mul_sum[WIDTH-1],
                      |mul_sum[2*WIDTH-1:WIDTH], 1'b0};
          done_d   = 1'b1;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Result_out = result_q;
  assign bus.Flags_out  = flags_q;
  assign bus.Busy       = (state_q == S_MUL_RUN);
  assign bus.Done       = done_q;
  assign bus.Halted     = (state_q == S_HALT);
  assign bus.Err        = err_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit at WIDTH=8 and WIDTH=16.
module tb_alu_seq_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(8))  if8 ();
  alu_seq_unit_if #(.WIDTH(16)) if16 ();

  alu_seq_unit #(.WIDTH(8))  u8  (.CLK(clk), .Reset_n(rst_n), .bus(if8));
  alu_seq_unit #(.WIDTH(16)) u16 (.CLK(clk), .Reset_n(rst_n), .bus(if16));

  typedef struct {
    logic        err;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t        sb8[$];
  exp_t        sb16[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_res8 = '0, last_res16 = '0;
  logic [3:0]  last_fl8 = '0, last_fl16 = '0;
  bit          halted8 = 1'b0, halted16 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: wide integer arithmetic, masked to w bits.
  function automatic void model(input int w, input logic [3:0] fs,
                                input logic [15:0] a_in, input logic [15:0] b_in,
                                output logic [15:0] r, output logic [3:0] fl);
    longint mask, half, ua, ub, sa, sb, x, s;
    logic   c, v;
    int     sh;
    mask = (64'sd1 << w) - 1;
    half = 64'sd1 << (w - 1);
    ua = longint'(a_in) & mask;
    ub = longint'(b_in) & mask;
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    sh = int'(ub & longint'(w - 1));
    x = ua; c = 1'b0; v = 1'b0;
    case (fs)
      4'd1: begin x = ua + ub; c = ((x >> w) & 1) != 0; s = sa + sb; v = (s < -half) || (s >= half); end
      4'd2: begin x = ub - ua; c = ub < ua; s = sb - sa; v = (s < -half) || (s >= half); end
      4'd3: begin x = (sa < 0) ? -sa : sa; v = (sa == -half); end
      4'd4: x = ~ua;
      4'd5: x = ua & ub;
      4'd6: begin x = -sa; v = (sa == -half); end
      4'd8: x = ua | ub;
      4'd9: x = ua ^ ub;
      4'd10: begin x = ua << sh; c = (sh != 0) && (((ua >> (w - sh)) & 1) != 0); end
      4'd11: begin x = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
      4'd12: begin x = ua * ub; c = (x >> w) != 0; end
      default: ;
    endcase
    r  = 16'(x & mask);
    fl = {(x & mask) == 0, (((x & mask) >> (w - 1)) & 1) != 0, c, v};
  endfunction

  // Drive one request for a single edge and record what it should produce.
  task automatic issue(input bit w16, input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] r;
    logic [3:0]  fl;
    @(negedge clk);
    if (w16) begin
      if16.Start = 1'b1; if16.FS = fs; if16.Data_in_A = a; if16.Data_in_B = b;
    end else begin
      if8.Start = 1'b1; if8.FS = fs; if8.Data_in_A = a[7:0]; if8.Data_in_B = b[7:0];
    end
    if (!(w16 ? halted16 : halted8)) begin
      if (fs == 4'd7) begin
        if (w16) halted16 = 1'b1; else halted8 = 1'b1;
      end else if (fs >= 4'd13) begin
        e.err = 1'b1;
        e.res = w16 ? last_res16 : last_res8;
        e.fl  = w16 ? last_fl16 : last_fl8;
        if (w16) sb16.push_back(e); else sb8.push_back(e);
      end else begin
        model(w16 ? 16 : 8, fs, a, b, r, fl);
        e.err = 1'b0; e.res = r; e.fl = fl;
        if (w16) begin sb16.push_back(e); last_res16 = r; last_fl16 = fl; end
        else     begin sb8.push_back(e);  last_res8 = r;  last_fl8 = fl;  end
      end
    end
    @(posedge clk);
    #1;
    if (w16) if16.Start = 1'b0; else if8.Start = 1'b0;
  endtask

  // Count Busy cycles, poking reserved-code Starts that must be ignored.
  task automatic wait_idle(input bit w16, output int n);
    n = 0;
    while ((w16 ? if16.Busy : if8.Busy) === 1'b1 && n < 100) begin
      n++;
      if (w16) begin if16.Start = n[0]; if16.FS = 4'd13; end
      else     begin if8.Start = n[0];  if8.FS = 4'd13;  end
      @(posedge clk);
      #1;
    end
    if8.Start = 1'b0;
    if16.Start = 1'b0;
  endtask

  task automatic score(input bit w16, input logic done, input logic err,
                       input logic [15:0] res, input logic [3:0] fl);
    exp_t e;
    if (done !== 1'b1 && err !== 1'b1) return;
    if ((w16 ? sb16.size() : sb8.size()) == 0) begin
      check(w16 ? "unexpected_evt16" : "unexpected_evt8", {30'd0, done, err}, 32'd0);
      return;
    end
    if (w16) e = sb16.pop_front(); else e = sb8.pop_front();
    check(w16 ? "kind16" : "kind8", {30'd0, done, err}, e.err ? 32'd1 : 32'd2);
    check(w16 ? "result16" : "result8", {16'd0, res}, {16'd0, e.res});
    check(w16 ? "flags16" : "flags8", {28'd0, fl}, {28'd0, e.fl});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      score(1'b0, if8.Done, if8.Err, {8'h00, if8.Result_out}, if8.Flags_out);
      score(1'b1, if16.Done, if16.Err, if16.Result_out, if16.Flags_out);
    end
  end

  task automatic clear_model();
    sb8.delete(); sb16.delete();
    last_res8 = '0; last_res16 = '0; last_fl8 = '0; last_fl16 = '0;
    halted8 = 1'b0; halted16 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] fs;
    if8.Start = 1'b0;  if8.FS = '0;  if8.Data_in_A = '0;  if8.Data_in_B = '0;
    if16.Start = 1'b0; if16.FS = '0; if16.Data_in_A = '0; if16.Data_in_B = '0;
    #12;
    check("reset8", {16'd0, if8.Result_out, if8.Flags_out, if8.Busy, if8.Done, if8.Halted, if8.Err}, 32'd0);
    check("reset16", {8'd0, if16.Result_out, if16.Flags_out, if16.Busy, if16.Done, if16.Halted, if16.Err}, 32'd0);
    #11 rst_n = 1'b1;

    // ADD overflow corner, Done exactly one cycle
    issue(1'b0, 4'd1, 16'h7F, 16'h01);
    check("add_res", {24'd0, if8.Result_out}, 32'h80);
    check("add_flags", {28'd0, if8.Flags_out}, 32'b0101);
    check("add_done", {31'd0, if8.Done}, 32'd1);
    check("add_busy", {31'd0, if8.Busy}, 32'd0);
    @(posedge clk); #1;
    check("add_done_drop", {31'd0, if8.Done}, 32'd0);

    // Back-to-back SUB / ABS / NEG corners
    issue(1'b0, 4'd2, 16'h05, 16'h03);
    check("sub_res", {24'd0, if8.Result_out}, 32'hFE);
    check("sub_c", {31'd0, if8.Flags_out[1]}, 32'd1);
    issue(1'b0, 4'd3, 16'h80, 16'h00);
    check("abs_res", {24'd0, if8.Result_out}, 32'h80);
    check("abs_v", {31'd0, if8.Flags_out[0]}, 32'd1);
    issue(1'b0, 4'd6, 16'h00, 16'h00);
    check("neg_res", {24'd0, if8.Result_out}, 32'h00);
    check("neg_z", {31'd0, if8.Flags_out[3]}, 32'd1);
    issue(1'b0, 4'd6, 16'h80, 16'h00);
    issue(1'b0, 4'd11, 16'h81, 16'h00);
    issue(1'b0, 4'd11, 16'h81, 16'h01);
    issue(1'b0, 4'd10, 16'h81, 16'h07);

    // Random single-cycle traffic, including reserved codes
    repeat (40) begin
      fs = 4'($urandom_range(0, 15));
      if (fs == 4'd7 || fs == 4'd12) fs = 4'd9;
      issue(1'b0, fs, 16'($urandom), 16'($urandom));
    end

    // Multiplier
    issue(1'b0, 4'd12, 16'h10, 16'h20);
    check("mul_busy_now", {31'd0, if8.Busy}, 32'd1);
    wait_idle(1'b0, n);
    check("mul8_busy_cycles", n, 32'd8);
    check("mul8_done", {31'd0, if8.Done}, 32'd1);
    check("mul8_res", {24'd0, if8.Result_out}, 32'h00);
    check("mul8_flags", {28'd0, if8.Flags_out}, 32'b1010);
    issue(1'b0, 4'd12, 16'h0C, 16'h0B);
    wait_idle(1'b0, n);
    check("mul8_res2", {24'd0, if8.Result_out}, 32'h84);
    check("mul8_c2", {31'd0, if8.Flags_out[1]}, 32'd0);
    repeat (4) begin
      issue(1'b0, 4'd12, 16'($urandom), 16'($urandom));
      wait_idle(1'b0, n);
      issue(1'b0, 4'd1, 16'($urandom), 16'($urandom));
    end

    // Reset in the third MUL_RUN cycle
    issue(1'b0, 4'd12, 16'hFF, 16'hFF);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_mid_mul", {16'd0, if8.Result_out, if8.Flags_out, if8.Busy, if8.Done, if8.Halted, if8.Err}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_rst", {31'd0, if8.Done}, 32'd0);
    issue(1'b0, 4'd1, 16'h02, 16'h03);
    check("add_after_rst", {24'd0, if8.Result_out}, 32'h05);

    // Reserved code, then halt
    issue(1'b0, 4'd13, 16'h11, 16'h22);
    check("err_pulse", {31'd0, if8.Err}, 32'd1);
    check("err_res_hold", {24'd0, if8.Result_out}, 32'h05);
    check("err_no_done", {31'd0, if8.Done}, 32'd0);
    issue(1'b0, 4'd7, 16'h00, 16'h00);
    check("halted", {31'd0, if8.Halted}, 32'd1);
    check("hlt_no_done", {30'd0, if8.Done, if8.Err}, 32'd0);
    issue(1'b0, 4'd1, 16'h01, 16'h01);
    issue(1'b0, 4'd14, 16'h01, 16'h01);
    check("halt_ignores", {30'd0, if8.Done, if8.Err}, 32'd0);
    check("halt_res_hold", {24'd0, if8.Result_out}, 32'h05);

    // WIDTH=16
    issue(1'b1, 4'd10, 16'h8001, 16'h0001);
    check("shl16_res", {16'd0, if16.Result_out}, 32'h0002);
    check("shl16_flags", {28'd0, if16.Flags_out}, 32'b0010);
    issue(1'b1, 4'd12, 16'h1234, 16'h0ABC);
    wait_idle(1'b1, n);
    check("mul16_busy_cycles", n, 32'd16);
    repeat (20) begin
      fs = 4'($urandom_range(0, 15));
      if (fs == 4'd7 || fs == 4'd12) fs = 4'd2;
      issue(1'b1, fs, 16'($urandom), 16'($urandom));
    end
    repeat (3) @(posedge clk);

    // Only reset leaves HALT
    check("still_halted", {31'd0, if8.Halted}, 32'd1);
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    check("halt_cleared", {31'd0, if8.Halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 4'd9, 16'h5A, 16'h0F);
    check("xor_after_halt", {24'd0, if8.Result_out}, 32'h55);
    repeat (3) @(posedge clk);

    check("sb8_drained", sb8.size(), 32'd0);
    check("sb16_drained", sb16.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
